ps2_kbd_ctrl: RTL and testbench

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_clk_filter.sv | 56 +++++
 rtl/ps2_kbd_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard host controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_LINEACK   = 3'd4,
    ST_WAIT_RESP = 3'd5,
    ST_ERR       = 3'd6
  } ps2_state_e;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_BAT    = 8'hAA;

  // 50 MHz system clock: 100 us inhibit, 15 ms per-edge/response timeout
  localparam int DEF_INHIBIT_CYC = 5000;
  localparam int DEF_TIMEOUT_CYC = 750000;
  localparam int DEF_FILTER_LEN  = 32;
  localparam int DEF_MAX_RETRY   = 3;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchronizers for the PS/2 lines plus a stability filter on the
// clock line that emits a single-cycle pulse on each filtered falling edge.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk_in,
  input  logic ps2dat_in,
  output logic clk_fall,
  output logic dat_sync
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          clk_sync_p0;
  logic          clk_sync_p1;
  logic          dat_sync_p0;
  logic          dat_sync_p1;
  logic          clk_filt;
  logic [CW-1:0] stable_cnt;

  // Lines idle high, so the synchronizers and the filtered level reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      dat_sync_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
      clk_filt    <= 1'b1;
      clk_fall    <= 1'b0;
      stable_cnt  <= '0;
    end else begin
      clk_sync_p0 <= ps2clk_in;
      clk_sync_p1 <= clk_sync_p0;
      dat_sync_p0 <= ps2dat_in;
      dat_sync_p1 <= dat_sync_p0;
      clk_fall    <= 1'b0;
      // The new level must persist FILTER_LEN consecutive cycles to be taken.
      if (clk_sync_p1 == clk_filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt   <= clk_sync_p1;
        clk_fall   <= ~clk_sync_p1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign dat_sync = dat_sync_p1;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard host controller: sends command bytes to the device with
// request-to-send, waits for 0xFA/0xFE, forwards all other received bytes.
// Define PS2_KBD_CTRL_AUTORETRY_EN to retry up to MAX_RETRY times before ERR.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       rx_strobe,
  input  logic [7:0] rx_data,
  output logic       fwd_valid,
  output logic [7:0] fwd_data,
  output logic       busy,
  output logic       ack_ok,
  output logic       err
);

  localparam int TMAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(MAX_RETRY + 1) + 1;

`ifdef PS2_KBD_CTRL_AUTORETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = 0;
`endif

  function automatic logic [TW-1:0] sat_inc_tmo(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [AW-1:0] sat_inc_att(input logic [AW-1:0] v);
    return (v == {AW{1'b1}}) ? v : v + 1'b1;
  endfunction

  ps2_state_e    state;
  ps2_state_e    state_n;
  logic [TW-1:0] tmo_cnt;
  logic [AW-1:0] attempts;
  logic [7:0]    tx_byte;
  logic [3:0]    bit_idx;
  logic          dat_drv;
  logic          tx_bit;
  logic          clk_fall;
  logic          dat_sync;
  logic          load_cmd;
  logic          retry_ev;
  logic          retry_ok;
  logic          tmo_hit;
  logic          in_frame;
  logic          rx_is_ack;
  logic          rx_is_resend;
  logic          rx_consumed;
  logic          tmo_clear;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2clk_in (ps2clk_in),
    .ps2dat_in (ps2dat_in),
    .clk_fall  (clk_fall),
    .dat_sync  (dat_sync)
  );

  assign retry_ok     = (int'(attempts) < RETRY_LIMIT);
  assign tmo_hit      = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign in_frame     = (state == ST_REQ) || (state == ST_SEND);
  assign rx_is_ack    = rx_strobe && (rx_data == PS2_ACK);
  assign rx_is_resend = rx_strobe && (rx_data == PS2_RESEND);
  // 0xFA/0xFE are consumed only as the command response; everything else is passed on.
  assign rx_consumed  = (state == ST_WAIT_RESP) && (rx_is_ack || rx_is_resend);

  always_comb begin
    state_n  = state;
    load_cmd = 1'b0;
    retry_ev = 1'b0;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          state_n  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (tmo_cnt == TW'(INHIBIT_CYC - 1)) state_n = ST_REQ;
      end
      ST_REQ: begin
        if (clk_fall)     state_n  = ST_SEND;
        else if (tmo_hit) retry_ev = 1'b1;
      end
      ST_SEND: begin
        if (clk_fall) begin
          if (bit_idx == 4'd9) state_n = ST_LINEACK;
        end else if (tmo_hit) begin
          retry_ev = 1'b1;
        end
      end
      ST_LINEACK: begin
        if (clk_fall) begin
          if (!dat_sync) state_n  = ST_WAIT_RESP;
          else           retry_ev = 1'b1;
        end else if (tmo_hit) begin
          retry_ev = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (rx_is_ack)                    state_n  = ST_IDLE;
        else if (rx_is_resend)            retry_ev = 1'b1;
        else if (!rx_strobe && tmo_hit)   retry_ev = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    if (retry_ev) state_n = retry_ok ? ST_INHIBIT : ST_ERR;
  end

  // Frame order after the start bit: data 0-7, odd parity, then released for stop.
  always_comb begin
    tx_bit = 1'b1;
    if (bit_idx < 4'd8)       tx_bit = tx_byte[bit_idx[2:0]];
    else if (bit_idx == 4'd8) tx_bit = odd_parity(tx_byte);
  end

  // Timeout restarts on every state entry, every device clock edge while
  // framing, and every forwarded byte while awaiting the response.
  assign tmo_clear = (state_n != state)
                  || (clk_fall && (in_frame || state == ST_LINEACK))
                  || ((state == ST_WAIT_RESP) && rx_strobe);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      attempts <= '0;
      bit_idx  <= '0;
      dat_drv  <= 1'b0;
    end else begin
      state   <= state_n;
      tmo_cnt <= tmo_clear ? '0 : sat_inc_tmo(tmo_cnt);
      // A fresh command starts a fresh retry budget; retries keep counting.
      if (load_cmd)                  attempts <= '0;
      else if (retry_ev && retry_ok) attempts <= sat_inc_att(attempts);
      if ((state_n == ST_REQ) && (state != ST_REQ)) begin
        bit_idx <= '0;
        dat_drv <= 1'b1;
      end else if (clk_fall && in_frame) begin
        bit_idx <= bit_idx + 1'b1;
        dat_drv <= ~tx_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_cmd) tx_byte <= cmd_data;
  end

  // Receive forwarding stage: one cycle of latency, independent of the transmit FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid <= 1'b0;
      fwd_data  <= 8'h00;
      ack_ok    <= 1'b0;
    end else begin
      fwd_valid <= rx_strobe && !rx_consumed;
      if (rx_strobe && !rx_consumed) fwd_data <= rx_data;
      ack_ok    <= (state == ST_WAIT_RESP) && rx_is_ack;
    end
  end

  assign ps2clk_oe = (state == ST_INHIBIT);
  assign ps2dat_oe = dat_drv && in_frame;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE) && (state != ST_ERR);
  assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomized bench for ps2_kbd_ctrl with an open-collector PS/2 device model
// and a command-level reference model of frames, retries and forwarding.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;

  localparam int INH = 20;
  localparam int TMO = 300;
  localparam int FLT = 4;
  localparam int MR  = 3;
  localparam int H   = 12;
  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;
`ifdef PS2_KBD_CTRL_AUTORETRY_EN
  localparam int ALLOWED = MR;
`else
  localparam int ALLOWED = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2clk_in, ps2dat_in, ps2clk_oe, ps2dat_oe;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       rx_strobe = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       fwd_valid;
  logic [7:0] fwd_data;
  logic       busy, ack_ok, err;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       dev_abort = 1'b0;
  int         dev_k = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  assign ps2clk_in = ~ps2clk_oe & dev_clk;
  assign ps2dat_in = ~ps2dat_oe & dev_dat;

  ps2_kbd_ctrl #(
    .INHIBIT_CYC (INH),
    .TIMEOUT_CYC (TMO),
    .FILTER_LEN  (FLT),
    .MAX_RETRY   (MR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2clk_in (ps2clk_in),
    .ps2dat_in (ps2dat_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rx_strobe (rx_strobe),
    .rx_data   (rx_data),
    .fwd_valid (fwd_valid),
    .fwd_data  (fwd_data),
    .busy      (busy),
    .ack_ok    (ack_ok),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected frame seen on the wire: data LSB first, odd parity, stop = 1.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b};
  endfunction

  function automatic logic [7:0] reply_for(input int scen, input int att);
    if (scen == 3) return RESEND;
    if (scen == 1 && att == 0) return RESEND;
    return ACK;
  endfunction

  task automatic dev_wait(input int n);
    for (int i = 0; i < n && !dev_abort; i++) @(negedge clk);
  endtask

  task automatic issue_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("cmd_busy", busy, 1);
    check_eq("cmd_clk_inhibit", ps2clk_oe, 1);
    check_eq("cmd_err_clear", err, 0);
    check_eq("cmd_ready_low", cmd_ready, 0);
  endtask

  // Device side of one host-to-device frame: times the inhibit, clocks 11
  // times, samples data at the end of each low phase, line-acks on clock 11.
  task automatic dev_frame(input logic [7:0] b, output logic [9:0] got);
    int guard;
    int inh;
    got   = '0;
    guard = 0;
    inh   = 0;
    while (!ps2clk_oe && guard < INH + TMO + 100 && !dev_abort) begin
      @(negedge clk);
      guard++;
    end
    if (dev_abort) return;
    if (!ps2clk_oe) begin
      check_eq("frame_start", 0, 1);
      return;
    end
    while (ps2clk_oe && inh < INH + 10) begin
      inh++;
      @(negedge clk);
    end
    check_eq("inhibit_len", inh, INH);
    check_eq("start_bit_drive", ps2dat_oe, 1);
    dev_wait(4);
    for (int k = 1; k <= 11 && !dev_abort; k++) begin
      dev_k = k;
      if (k == 11) dev_dat = 1'b0;
      dev_clk = 1'b0;
      dev_wait(H);
      if (k <= 10) got[k-1] = ps2dat_in;
      dev_clk = 1'b1;
      dev_wait(H);
      dev_dat = 1'b1;
    end
    dev_k   = 0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    if (dev_abort) return;
    check_eq("frame_bits", got, model_frame(b));
    check_eq("busy_in_wait", busy, 1);
  endtask

  task automatic rx_pulse(input logic [7:0] d, input bit exp_fwd, input bit exp_ack);
    @(negedge clk);
    rx_strobe = 1'b1;
    rx_data   = d;
    @(negedge clk);
    rx_strobe = 1'b0;
    check_eq("fwd_valid", fwd_valid, exp_fwd);
    if (exp_fwd) check_eq("fwd_data", fwd_data, d);
    check_eq("ack_ok", ack_ok, exp_ack);
  endtask

  task automatic inject_rx(input logic [7:0] d);
    int guard;
    guard = 0;
    while (dev_k != 5 && guard < INH + TMO) begin
      @(negedge clk);
      guard++;
    end
    if (dev_k != 5) check_eq("inject_wait", 0, 1);
    else            rx_pulse(d, 1'b1, 1'b0);
  endtask

  task automatic quiet_check(input string tag);
    int highs;
    highs = 0;
    for (int i = 0; i < 2 * INH; i++) begin
      @(negedge clk);
      if (ps2clk_oe) highs++;
    end
    check_eq(tag, highs, 0);
  endtask

  // One command against a scripted device; the model predicts the frame count and outcome.
  task automatic run_cmd(input logic [7:0] b, input int scen, input bit inject,
                         input logic [7:0] inj_byte, input logic [7:0] extra,
                         output logic [9:0] first_frame);
    int nfr;
    bit exp_err;
    logic [9:0] got;
    logic [7:0] rep;
    nfr     = 0;
    exp_err = 1'b0;
    for (int a = 0; a < 16; a++) begin
      nfr++;
      if (reply_for(scen, a) == ACK) break;
      if (nfr > ALLOWED) begin
        exp_err = 1'b1;
        break;
      end
    end
    first_frame = '0;
    issue_cmd(b);
    for (int a = 0; a < nfr; a++) begin
      if (inject && a == 0) begin
        fork
          dev_frame(b, got);
          inject_rx(inj_byte);
        join
      end else begin
        dev_frame(b, got);
      end
      if (a == 0) first_frame = got;
      if (scen == 2) rx_pulse(extra, 1'b1, 1'b0);
      rep = reply_for(scen, a);
      rx_pulse(rep, 1'b0, rep == ACK);
    end
    if (exp_err) begin
      check_eq("end_err", err, 1);
      check_eq("end_err_ready", cmd_ready, 0);
      check_eq("end_err_lines", {ps2clk_oe, ps2dat_oe}, 0);
      quiet_check("err_quiet");
    end else begin
      check_eq("end_busy", busy, 0);
      check_eq("end_ready", cmd_ready, 1);
      check_eq("end_err_low", err, 0);
      quiet_check("idle_quiet");
    end
  endtask

  initial begin
    logic [9:0] ff;
    int t;
    int frames;
    int exp_t;
    logic prev;

    repeat (3) @(negedge clk);
    check_eq("rst_clk_oe", ps2clk_oe, 0);
    check_eq("rst_dat_oe", ps2dat_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack", ack_ok, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_fwd_valid", fwd_valid, 0);
    check_eq("rst_fwd_data", fwd_data, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", cmd_ready, 1);

    // 0xED with a SEND-time rx of 0x1C and a WAIT_RESP rx of 0xAA
    run_cmd(8'hED, 2, 1'b1, 8'h1C, 8'hAA, ff);
    check_eq("ed_bits", ff, 10'b11_1110_1101);

    // 0x01: resend then ack
    run_cmd(8'h01, 1, 1'b0, 8'h00, 8'h00, ff);
    check_eq("x01_bits", ff, 10'b10_0000_0001);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      logic [7:0] inj;
      logic [7:0] ex;
      int scen;
      bit inject;
      b      = 8'($urandom);
      inj    = 8'($urandom);
      ex     = 8'($urandom_range(0, 8'hF9));
      scen   = $urandom_range(0, 2);
      inject = 1'($urandom_range(0, 1));
      run_cmd(b, scen, inject, inj, ex, ff);
    end

    // 0xFF: device always asks for a resend
    run_cmd(8'hFF, 3, 1'b0, 8'h00, 8'h00, ff);
    check_eq("ff_err", err, 1);

    // Silent device, started from ERR
    issue_cmd(8'h55);
    exp_t  = (ALLOWED + 1) * (INH + TMO);
    t      = 0;
    frames = 1;
    prev   = ps2clk_oe;
    while (!err && t < 2 * exp_t) begin
      @(negedge clk);
      t++;
      if (ps2clk_oe && !prev) frames++;
      prev = ps2clk_oe;
    end
    check_eq("timeout_cycles", t, exp_t);
    check_eq("timeout_frames", frames, ALLOWED + 1);
    check_eq("timeout_lines", {ps2clk_oe, ps2dat_oe}, 0);

    // Reset while bit 4 (a zero, so the host is driving data low) is on the wire
    issue_cmd(8'hED);
    fork
      dev_frame(8'hED, ff);
      begin
        int guard;
        guard = 0;
        while (dev_k != 5 && guard < INH + TMO) begin
          @(negedge clk);
          guard++;
        end
        repeat (9) @(negedge clk);
        check_eq("bit4_driven", {ps2clk_oe, ps2dat_oe}, 2'b01);
        #1 reset = 1'b0;
        #1;
        check_eq("rst_mid_lines", {ps2clk_oe, ps2dat_oe}, 0);
        dev_abort = 1'b1;
      end
    join
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_err", err, 0);
    check_eq("rst_mid_fwd", {fwd_valid, fwd_data}, 0);
    repeat (3) @(negedge clk);
    reset     = 1'b1;
    dev_abort = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", cmd_ready, 1);
    run_cmd(8'h3C, 0, 1'b0, 8'h00, 8'h00, ff);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
